// File: rtl/encoder_index_fifo_pkg.sv
// ============================================================================
// encoder_pkg : width helpers shared by the encoder index FIFO slice
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package encoder_pkg;

  // Binary index width for a one-hot vector; never narrower than one bit.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Occupancy counter width; one extra bit so DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Packed entry width: msb index, lsb index, span (one bit wider) and zero flag.
  function automatic int entry_width(input int width);
    return 3 * idx_width(width) + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_index_fifo_if.sv
// ============================================================================
// encoder_index_fifo_if : valid/ready drain port of the encoder index FIFO
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface encoder_index_fifo_if
  import encoder_pkg::*;
#(
  parameter int WIDTH = 16
);
  localparam int IDX_W = idx_width(WIDTH);

  logic [IDX_W-1:0] msb_idx_o;
  logic [IDX_W-1:0] lsb_idx_o;
  logic [IDX_W:0]   span_o;
  logic             zero_o;
  logic             out_val_o;
  logic             out_ready_i;

  modport master (
    output msb_idx_o, lsb_idx_o, span_o, zero_o, out_val_o,
    input  out_ready_i
  );

  modport slave (
    input  msb_idx_o, lsb_idx_o, span_o, zero_o, out_val_o,
    output out_ready_i
  );

endinterface

`default_nettype wire

// File: rtl/encoder_index_fifo_onehot_to_bin.sv
// ============================================================================
// onehot_to_bin : combinational one-hot to binary index (OR of set positions)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_to_bin
  import encoder_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o
);

  // Exact for a true one-hot; malformed inputs yield the OR of all positions.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_i[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/encoder_index_fifo.sv
// ============================================================================
// encoder_index_fifo : encoder one-hot pair -> index/span entries, drop on full
// Optional malformed-input check and err_o port: ENCODER_ONEHOT_CHECK_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_index_fifo
  import encoder_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int IDX_W = idx_width(WIDTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [WIDTH-1:0]     data_left_i,
  input  logic [WIDTH-1:0]     data_right_i,
  input  logic                 data_val_i,
  encoder_index_fifo_if.master out_if,
  output logic [CNT_W-1:0]     used_o,
  output logic                 drop_o
`ifdef ENCODER_ONEHOT_CHECK_EN
  ,
  output logic                 err_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] msb_idx;
    logic [IDX_W-1:0] lsb_idx;
    logic [IDX_W:0]   span;
    logic             zero;
  } entry_t;

  logic [IDX_W-1:0] w_msb;
  logic [IDX_W-1:0] w_lsb;
  entry_t           w_entry;
  entry_t           w_head;
  logic             w_malformed;
  logic             w_out_val;
  logic             w_pop;
  logic             w_space;
  logic             w_push;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_used;
  logic             r_drop;

  onehot_to_bin #(.WIDTH(WIDTH)) u_left (
    .onehot_i (data_left_i),
    .idx_o    (w_msb)
  );

  onehot_to_bin #(.WIDTH(WIDTH)) u_right (
    .onehot_i (data_right_i),
    .idx_o    (w_lsb)
  );

  // Span is computed one bit wider so a full-width vector reports WIDTH.
  always_comb begin
    w_entry         = '0;
    w_entry.msb_idx = w_msb;
    w_entry.lsb_idx = w_lsb;
    w_entry.zero    = ~|data_left_i & ~|data_right_i;
    w_entry.span    = w_entry.zero ? '0
                    : {1'b0, w_msb} - {1'b0, w_lsb} + (IDX_W+1)'(1);
  end

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic w_multi_left;
  logic w_multi_right;
  logic w_half_zero;
  logic r_err;

  // v & (v-1) is non-zero exactly when more than one bit is set.
  assign w_multi_left  = |(data_left_i  & (data_left_i  - WIDTH'(1)));
  assign w_multi_right = |(data_right_i & (data_right_i - WIDTH'(1)));
  assign w_half_zero   = (~|data_left_i) ^ (~|data_right_i);
  assign w_malformed   = w_multi_left | w_multi_right | w_half_zero | (w_lsb > w_msb);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_err <= 1'b0;
    else        r_err <= data_val_i & w_malformed;
  end

  assign err_o = r_err;
`else
  assign w_malformed = 1'b0;
`endif

  assign w_out_val = (r_used != '0);
  assign w_pop     = w_out_val & out_if.out_ready_i;
  assign w_space   = (r_used != CNT_W'(DEPTH)) | w_pop;
  assign w_push    = data_val_i & w_space & ~w_malformed;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= data_val_i & ~w_push;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_used <= r_used + CNT_W'(1);
        2'b01:   r_used <= r_used - CNT_W'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  // Storage is intentionally not reset; the count alone defines validity.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head            = r_mem[r_rd_ptr];
  assign out_if.out_val_o  = w_out_val;
  assign out_if.msb_idx_o  = w_out_val ? w_head.msb_idx : '0;
  assign out_if.lsb_idx_o  = w_out_val ? w_head.lsb_idx : '0;
  assign out_if.span_o     = w_out_val ? w_head.span    : '0;
  assign out_if.zero_o     = w_out_val ? w_head.zero    : 1'b0;
  assign used_o            = r_used;
  assign drop_o            = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_encoder_index_fifo.sv
// ============================================================================
// tb_encoder_index_fifo : table vectors plus scoreboard for encoder_index_fifo
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder_index_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [3:0] msb;
    logic [3:0] lsb;
    logic [4:0] span;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    exp_t        exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic [15:0]      data_left = '0;
  logic [15:0]      data_right = '0;
  logic             data_val = 1'b0;
  logic [CNT_W-1:0] used;
  logic             drop;
`ifdef ENCODER_ONEHOT_CHECK_EN
  logic             err;
`endif

  encoder_index_fifo_if #(.WIDTH(WIDTH)) out_if ();

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[6];

  always #5 clk = ~clk;

  encoder_index_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .data_left_i  (data_left),
    .data_right_i (data_right),
    .data_val_i   (data_val),
    .out_if       (out_if),
    .used_o       (used),
    .drop_o       (drop)
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    .err_o        (err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) e.msb = e.msb | 4'(i);
      if (r[i]) e.lsb = e.lsb | 4'(i);
    end
    e.zero = (l == 16'h0) && (r == 16'h0);
    e.span = e.zero ? 5'd0 : 5'(int'(e.msb) - int'(e.lsb) + 1);
    return e;
  endfunction

  function automatic bit is_malformed(input logic [15:0] l, input logic [15:0] r);
`ifdef ENCODER_ONEHOT_CHECK_EN
    exp_t e;
    if ($countones(l) > 1 || $countones(r) > 1) return 1'b1;
    if ((l == 16'h0) != (r == 16'h0)) return 1'b1;
    e = model(l, r);
    return (l != 16'h0) && (e.lsb > e.msb);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive, check head/state mid-cycle, update model, check drop after edge.
  task automatic cycle(input logic [15:0] l, input logic [15:0] r,
                       input logic v, input logic rdy, input exp_t e);
    bit pop, space, mal;
    data_left = l; data_right = r; data_val = v; out_if.out_ready_i = rdy;
    #2;
    chk("used", 32'(used), 32'(q.size()));
    chk("out_val", 32'(out_if.out_val_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_msb",  32'(out_if.msb_idx_o), 32'(q[0].msb));
      chk("head_lsb",  32'(out_if.lsb_idx_o), 32'(q[0].lsb));
      chk("head_span", 32'(out_if.span_o),    32'(q[0].span));
      chk("head_zero", 32'(out_if.zero_o),    32'(q[0].zero));
    end
    pop   = (q.size() != 0) && rdy;
    space = (q.size() < DEPTH) || pop;
    mal   = is_malformed(l, r);
    if (pop) void'(q.pop_front());
    if (v && space && !mal) q.push_back(e);
    @(posedge clk); #1;
    chk("drop", 32'(drop), 32'(v && (!space || mal)));
`ifdef ENCODER_ONEHOT_CHECK_EN
    chk("err", 32'(err), 32'(v && mal));
`endif
  endtask

  task automatic push_rand(input logic rdy);
    int lo, hi;
    logic [15:0] l, r;
    lo = $urandom_range(0, 15);
    hi = $urandom_range(lo, 15);
    l = 16'h1 << hi;
    r = 16'h1 << lo;
    cycle(l, r, 1'b1, rdy, model(l, r));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    out_if.out_ready_i = 1'b0;
    tbl[0] = '{16'h0080, 16'h0004, exp_t'{4'd7,  4'd2,  5'd6,  1'b0}};
    tbl[1] = '{16'h0000, 16'h0000, exp_t'{4'd0,  4'd0,  5'd0,  1'b1}};
    tbl[2] = '{16'h8000, 16'h0001, exp_t'{4'd15, 4'd0,  5'd16, 1'b0}};
    tbl[3] = '{16'h0001, 16'h0001, exp_t'{4'd0,  4'd0,  5'd1,  1'b0}};
    tbl[4] = '{16'h0400, 16'h0010, exp_t'{4'd10, 4'd4,  5'd7,  1'b0}};
    tbl[5] = '{16'h8000, 16'h8000, exp_t'{4'd15, 4'd15, 5'd1,  1'b0}};

    @(posedge clk); #1;
    chk("rst_used", 32'(used), 0);
    chk("rst_out_val", 32'(out_if.out_val_o), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_msb", 32'(out_if.msb_idx_o), 0);
    chk("rst_lsb", 32'(out_if.lsb_idx_o), 0);
    chk("rst_span", 32'(out_if.span_o), 0);
    chk("rst_zero", 32'(out_if.zero_o), 0);
    arst = 1'b0;
    @(posedge clk); #1;

    // Table: write with no ready, hold one cycle, then pop.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].left, tbl[i].right, 1'b1, 1'b0, tbl[i].exp);
      cycle('0, '0, 1'b0, 1'b0, '0);
      cycle('0, '0, 1'b0, 1'b1, '0);
    end

    // Overflow: fifth write dropped, then drain in order.
    for (int i = 0; i < 5; i++) push_rand(1'b0);
    drain(5);

    // Full with simultaneous push/pop, then stream for wrap-around.
    for (int i = 0; i < 4; i++) push_rand(1'b0);
    push_rand(1'b1);
    for (int i = 0; i < 10; i++) push_rand(1'b1);
    for (int i = 0; i < 6; i++) push_rand(1'($urandom_range(0, 1)));
    drain(6);

    // Asynchronous reset mid-cycle with three entries queued.
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_out_val", 32'(out_if.out_val_o), 0);
    chk("arst_used", 32'(used), 0);
    q.delete();
    @(posedge clk); #1;
    arst = 1'b0;
    push_rand(1'b0);
    push_rand(1'b0);
    drain(3);

    // Malformed vectors: rejected with err when checked, else OR-encoded.
    cycle(16'h0030, 16'h0010, 1'b1, 1'b0, model(16'h0030, 16'h0010));
    cycle(16'h0004, 16'h0080, 1'b1, 1'b0, model(16'h0004, 16'h0080));
    cycle(16'h0010, 16'h0000, 1'b1, 1'b0, model(16'h0010, 16'h0000));
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
